// File: rtl/seq_alu.sv
// +----------------------------------------------------------------------------+
// | seq_alu : handshaked sequential ALU, single-cycle logic/arith/shift ops and |
// |           optional iterative shift-add multiplier (macro SEQ_ALU_MUL_EN).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_n,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] c_op_add = 3'd0;
   localparam logic [2:0] c_op_sub = 3'd1;
   localparam logic [2:0] c_op_and = 3'd2;
   localparam logic [2:0] c_op_or  = 3'd3;
   localparam logic [2:0] c_op_xor = 3'd4;
   localparam logic [2:0] c_op_shl = 3'd5;
   localparam logic [2:0] c_op_shr = 3'd6;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [2:0] c_op_mul = 3'd7;
   localparam int         CW       = SHW + 1;
   localparam logic [CW-1:0] c_cnt_load = CW'(WIDTH);
   localparam logic [CW-1:0] c_cnt_one  = CW'(1);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd1
`ifdef SEQ_ALU_MUL_EN
      ,
      S_MUL  = 2'd2
`endif
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic [WIDTH-1:0] r_result_hi, w_result_hi_nxt;
   logic             r_flag_c, w_flag_c_nxt;
   logic             r_flag_v, w_flag_v_nxt;
   logic             r_flag_z, w_flag_z_nxt;
   logic             r_flag_n, w_flag_n_nxt;
   logic             r_err, w_err_nxt;

`ifdef SEQ_ALU_MUL_EN
   logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
   logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
   logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
   logic [CW-1:0]      r_cnt, w_cnt_nxt;
   logic [2*WIDTH-1:0] w_prod_step;
`endif

   logic             w_accept;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [SHW-1:0]   w_amt;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c;
   logic             w_alu_v;
   logic             w_alu_err;

   assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign w_accept = in_valid && in_ready;

   // Extra top bit of the sum/difference is the carry/borrow; shifts carry the
   // last bit pushed out in the extended position (0 when the amount is 0).
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_amt  = b[SHW-1:0];
   assign w_shl  = {1'b0, a} << w_amt;
   assign w_shr  = {a, 1'b0} >> w_amt;

   always_comb begin
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_v   = 1'b0;
      w_alu_err = 1'b0;
      case (op)
         c_op_add: begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_alu_c   = w_sum[WIDTH];
            w_alu_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
         end
         c_op_sub: begin
            w_alu_res = w_diff[WIDTH-1:0];
            w_alu_c   = w_diff[WIDTH];
            w_alu_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
         end
         c_op_and: w_alu_res = a & b;
         c_op_or:  w_alu_res = a | b;
         c_op_xor: w_alu_res = a ^ b;
         c_op_shl: {w_alu_c, w_alu_res} = w_shl;
         c_op_shr: {w_alu_res, w_alu_c} = w_shr;
         default:  w_alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flag_c    <= 1'b0;
         r_flag_v    <= 1'b0;
         r_flag_z    <= 1'b0;
         r_flag_n    <= 1'b0;
         r_err       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_prod      <= '0;
         r_cnt       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_result    <= w_result_nxt;
         r_result_hi <= w_result_hi_nxt;
         r_flag_c    <= w_flag_c_nxt;
         r_flag_v    <= w_flag_v_nxt;
         r_flag_z    <= w_flag_z_nxt;
         r_flag_n    <= w_flag_n_nxt;
         r_err       <= w_err_nxt;
`ifdef SEQ_ALU_MUL_EN
         r_mcand     <= w_mcand_nxt;
         r_mplier    <= w_mplier_nxt;
         r_prod      <= w_prod_nxt;
         r_cnt       <= w_cnt_nxt;
`endif
      end
   end

`ifdef SEQ_ALU_MUL_EN
   assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_out_valid_nxt = r_out_valid;
      w_result_nxt    = r_result;
      w_result_hi_nxt = r_result_hi;
      w_flag_c_nxt    = r_flag_c;
      w_flag_v_nxt    = r_flag_v;
      w_flag_z_nxt    = r_flag_z;
      w_flag_n_nxt    = r_flag_n;
      w_err_nxt       = r_err;
`ifdef SEQ_ALU_MUL_EN
      w_mcand_nxt     = r_mcand;
      w_mplier_nxt    = r_mplier;
      w_prod_nxt      = r_prod;
      w_cnt_nxt       = r_cnt;
`endif
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
`ifdef SEQ_ALU_MUL_EN
               if (op == c_op_mul) begin
                  w_mcand_nxt     = {{WIDTH{1'b0}}, a};
                  w_mplier_nxt    = b;
                  w_prod_nxt      = '0;
                  w_cnt_nxt       = c_cnt_load;
                  w_out_valid_nxt = 1'b0;
                  w_state_nxt     = S_MUL;
               end else
`endif
               begin
                  w_result_nxt    = w_alu_res;
                  w_result_hi_nxt = '0;
                  w_flag_c_nxt    = w_alu_c;
                  w_flag_v_nxt    = w_alu_v;
                  w_flag_z_nxt    = (w_alu_res == '0);
                  w_flag_n_nxt    = w_alu_res[MSB];
                  w_err_nxt       = w_alu_err;
                  w_out_valid_nxt = 1'b1;
                  w_state_nxt     = S_DONE;
               end
            end else if ((r_state == S_DONE) && out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
`ifdef SEQ_ALU_MUL_EN
         S_MUL: begin
            // One multiplier bit per clock; the last step publishes the product.
            w_prod_nxt   = w_prod_step;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_cnt_nxt    = r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
               w_result_nxt    = w_prod_step[WIDTH-1:0];
               w_result_hi_nxt = w_prod_step[2*WIDTH-1:WIDTH];
               w_flag_c_nxt    = |w_prod_step[2*WIDTH-1:WIDTH];
               w_flag_v_nxt    = |w_prod_step[2*WIDTH-1:WIDTH];
               w_flag_z_nxt    = (w_prod_step == '0);
               w_flag_n_nxt    = w_prod_step[MSB];
               w_err_nxt       = 1'b0;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end
         end
`endif
         default: begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
         end
      endcase
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flag_c    = r_flag_c;
   assign flag_v    = r_flag_v;
   assign flag_z    = r_flag_z;
   assign flag_n    = r_flag_n;
   assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// +----------------------------------------------------------------------------+
// | tb_seq_alu : directed self-checking bench for seq_alu (WIDTH=8).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_alu;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             flag_c, flag_v, flag_z, flag_n, err;

   int n_checks = 0;
   int n_fail   = 0;

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Flags vector order: {c, v, z, n, err}
   task automatic expect_res(input string tag, input logic [7:0] r, input logic [7:0] h,
                             input logic [4:0] f);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " result"}, 32'(result), 32'(r));
      check({tag, " result_hi"}, 32'(result_hi), 32'(h));
      check({tag, " flags"}, 32'({flag_c, flag_v, flag_z, flag_n, err}), 32'(f));
   endtask

   // Offer one op, then scramble the operands and count edges until out_valid.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input int exp_lat);
      int lat;
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; op = 3'd2; a = 8'h5A; b = 8'hA5;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'({result_hi, result}), 32'd0);
      check("reset flags", 32'({flag_c, flag_v, flag_z, flag_n, err}), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("add7f", 3'd0, 8'h7F, 8'h01, 1); expect_res("add7f", 8'h80, 8'h00, 5'b01010);
      do_op("sub", 3'd1, 8'h05, 8'h07, 1);   expect_res("sub", 8'hFE, 8'h00, 5'b10010);
      do_op("shl", 3'd5, 8'h81, 8'h01, 1);   expect_res("shl", 8'h02, 8'h00, 5'b10000);
      do_op("shr", 3'd6, 8'h01, 8'h09, 1);   expect_res("shr", 8'h00, 8'h00, 5'b10100);
      do_op("shl0", 3'd5, 8'h80, 8'h08, 1);  expect_res("shl0", 8'h80, 8'h00, 5'b00010);
      do_op("addff", 3'd0, 8'hFF, 8'h01, 1); expect_res("addff", 8'h00, 8'h00, 5'b10100);
      do_op("and", 3'd2, 8'hF0, 8'h3C, 1);   expect_res("and", 8'h30, 8'h00, 5'b00000);
      do_op("or", 3'd3, 8'h80, 8'h01, 1);    expect_res("or", 8'h81, 8'h00, 5'b00010);

      // Back-pressure: hold the result, then hand over and accept in one edge.
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_op("bp add", 3'd0, 8'h10, 8'h20, 1); expect_res("bp add", 8'h30, 8'h00, 5'b00000);
      repeat (3) begin
         @(posedge clk); #1;
         check("bp hold valid", 32'(out_valid), 32'd1);
         check("bp hold result", 32'(result), 32'h30);
         check("bp in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd4; a = 8'hF0; b = 8'hFF;
      #1 check("bp xor in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_res("bp xor", 8'h0F, 8'h00, 5'b00000);
      @(posedge clk); #1;
      check("bp drop valid", 32'(out_valid), 32'd0);

      // Back-to-back single-cycle ops with out_ready high.
      @(negedge clk);
      in_valid = 1'b1; op = 3'd0; a = 8'h01; b = 8'h02;
      @(posedge clk); #1;
      op = 3'd1; a = 8'h09; b = 8'h04;
      expect_res("b2b first", 8'h03, 8'h00, 5'b00000);
      check("b2b in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_res("b2b second", 8'h05, 8'h00, 5'b00000);

`ifdef SEQ_ALU_MUL_EN
      do_op("mulff", 3'd7, 8'hFF, 8'hFF, 9); expect_res("mulff", 8'h01, 8'hFE, 5'b11000);
      do_op("mul34", 3'd7, 8'h03, 8'h04, 9); expect_res("mul34", 8'h0C, 8'h00, 5'b00000);
      do_op("mul0", 3'd7, 8'h00, 8'h05, 9);  expect_res("mul0", 8'h00, 8'h00, 5'b00100);
      do_op("mul80", 3'd7, 8'h80, 8'h02, 9); expect_res("mul80", 8'h00, 8'h01, 5'b11000);
      do_op("pre rst", 3'd0, 8'h03, 8'h04, 1); expect_res("pre rst", 8'h07, 8'h00, 5'b00000);
      // Reset lands in the fourth iteration cycle of a multiply.
      @(negedge clk);
      in_valid = 1'b1; op = 3'd7; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mul busy in_ready", 32'(in_ready), 32'd0);
      check("mul busy valid", 32'(out_valid), 32'd0);
      repeat (3) @(posedge clk);
      #3;
`else
      do_op("op7", 3'd7, 8'h03, 8'h04, 1); expect_res("op7", 8'h00, 8'h00, 5'b00101);
      do_op("clr err", 3'd0, 8'h01, 8'h02, 1); expect_res("clr err", 8'h03, 8'h00, 5'b00000);
      // Reset lands while a result is held under back-pressure.
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_op("pre rst", 3'd0, 8'h03, 8'h04, 1); expect_res("pre rst", 8'h07, 8'h00, 5'b00000);
      @(posedge clk); #3;
`endif
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", 32'({result_hi, result}), 32'd0);
      check("rst flags", 32'({flag_c, flag_v, flag_z, flag_n, err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      do_op("post rst", 3'd0, 8'h01, 8'h01, 1); expect_res("post rst", 8'h02, 8'h00, 5'b00000);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
